// File: rtl/cpu_multicycle_param.sv
// Parametrised multi-cycle CPU: 32-bit instructions fetched over a req/valid
// handshake, sequenced FETCH -> DECODE -> EXEC -> WB, with an internal
// register file, j/beq branches, halt and a sticky illegal-opcode flag.
module cpu_multicycle_param #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] PC,
  output logic        INSTR_REQ,
  input  logic        INSTR_VALID,
  input  logic [31:0] INSTRUCTION,
  output logic        RETIRED,
  output logic        HALTED,
  output logic        ILLEGAL
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state_r, state_next_s;

  logic [31:0]       pc_r;
  logic [31:0]       npc_r;
  logic [31:0]       ir_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] res_r;
  logic              wen_r;
  logic              illegal_r;
  logic [DATA_W-1:0] regs_r [NREGS];

  // Instruction fields; only the low REG_ADDR_W bits of each register field matter
  logic [7:0]            opcode_s;
  logic [REG_ADDR_W-1:0] dst_s;
  logic [REG_ADDR_W-1:0] src1_s;
  logic [REG_ADDR_W-1:0] src2_s;
  logic [DATA_W-1:0]     imm_ext_s;
  logic [31:0]           off_ext_s;
  logic [31:0]           pc_plus4_s;
  logic [31:0]           branch_pc_s;
  logic                  unused_ir_bits_s;

  assign opcode_s    = ir_r[31:24];
  assign dst_s       = ir_r[16 +: REG_ADDR_W];
  assign src1_s      = ir_r[8 +: REG_ADDR_W];
  assign src2_s      = ir_r[0 +: REG_ADDR_W];
  assign imm_ext_s   = DATA_W'(signed'(ir_r[7:0]));
  assign off_ext_s   = 32'(signed'(ir_r[23:16]));
  assign pc_plus4_s  = pc_r + 32'd4;
  assign branch_pc_s = pc_plus4_s + {off_ext_s[29:0], 2'b00};
  assign unused_ir_bits_s = ^ir_r[15:8];

  // ALU / control decode results used in EXEC
  logic [DATA_W-1:0] alu_s;
  logic              wen_s;
  logic [31:0]       npc_s;
  logic              illegal_s;

  // State register: async reset to FETCH
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: fetch waits for the memory ack, halt is absorbing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (INSTR_VALID) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: state_next_s = S_EXEC;
      S_EXEC: begin
        if (opcode_s == OP_HALT) begin
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_WB;
        end
      end
      S_WB:    state_next_s = S_FETCH;
      S_HALT:  state_next_s = S_HALT;
      default: state_next_s = S_FETCH;
    endcase
  end

  // Outputs decoded from state; the request drops as soon as reset asserts
  always_comb begin
    INSTR_REQ = (state_r == S_FETCH) && RESET_N;
    RETIRED   = (state_r == S_WB);
    HALTED    = (state_r == S_HALT);
    PC        = pc_r;
    ILLEGAL   = illegal_r;
  end

  // Execute stage combinational ALU, write enable and next-PC selection
  always_comb begin
    alu_s     = '0;
    wen_s     = 1'b0;
    npc_s     = pc_plus4_s;
    illegal_s = 1'b0;
    case (opcode_s)
      OP_LOADI: begin alu_s = imm_ext_s; wen_s = 1'b1; end
      OP_MOV:   begin alu_s = b_r;       wen_s = 1'b1; end
      OP_ADD:   begin alu_s = a_r + b_r; wen_s = 1'b1; end
      OP_SUB:   begin alu_s = a_r - b_r; wen_s = 1'b1; end
      OP_AND:   begin alu_s = a_r & b_r; wen_s = 1'b1; end
      OP_OR:    begin alu_s = a_r | b_r; wen_s = 1'b1; end
      OP_J:     npc_s = branch_pc_s;
      OP_BEQ: begin
        if (a_r == b_r) begin
          npc_s = branch_pc_s;
        end else begin
          npc_s = pc_plus4_s;
        end
      end
      OP_HALT:  npc_s = pc_r;
      default:  illegal_s = 1'b1;
    endcase
  end

  // Datapath: IR latch, operand read, result capture, register write-back and PC update
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_r      <= 32'd0;
      npc_r     <= 32'd0;
      ir_r      <= 32'd0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      wen_r     <= 1'b0;
      illegal_r <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      case (state_r)
        S_FETCH: begin
          if (INSTR_VALID) begin
            ir_r <= INSTRUCTION;
          end
        end
        S_DECODE: begin
          a_r <= regs_r[src1_s];
          b_r <= regs_r[src2_s];
        end
        S_EXEC: begin
          res_r <= alu_s;
          wen_r <= wen_s;
          npc_r <= npc_s;
          if (illegal_s) begin
            illegal_r <= 1'b1;
          end
        end
        S_WB: begin
          if (wen_r) begin
            regs_r[dst_s] <= res_r;
          end
          pc_r <= npc_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_param.sv
// Self-checking bench for cpu_multicycle_param: the bench plays instruction
// memory, supplying each instruction on demand, and predicts PC, retire timing,
// ILLEGAL and HALTED from an instruction-level reference model. Register
// contents are observed through beq outcomes against freshly loaded values.
module tb_cpu_multicycle_param;

  localparam int DW = 8;
  localparam int RW = 3;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] PC;
  logic        INSTR_REQ;
  logic        INSTR_VALID;
  logic [31:0] INSTRUCTION;
  logic        RETIRED;
  logic        HALTED;
  logic        ILLEGAL;

  cpu_multicycle_param #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .INSTR_REQ(INSTR_REQ),
    .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
    .RETIRED(RETIRED), .HALTED(HALTED), .ILLEGAL(ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mreg [8];
  logic [31:0] mpc;
  logic        mill;
  logic        mhalt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                     input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mpc   = 32'd0;
    mill  = 1'b0;
    mhalt = 1'b0;
  endtask

  // Instruction-level semantics
  task automatic model_apply(input logic [31:0] ins);
    logic [7:0]  op, a, b;
    logic [31:0] br;
    int d, s1, s2;
    op = ins[31:24];
    d  = int'(ins[18:16]);
    s1 = int'(ins[10:8]);
    s2 = int'(ins[2:0]);
    a  = mreg[s1];
    b  = mreg[s2];
    br = mpc + 32'd4 + 32'(4 * int'($signed(ins[23:16])));
    case (op)
      8'h00: begin mreg[d] = ins[7:0]; mpc = mpc + 32'd4; end
      8'h01: begin mreg[d] = b;        mpc = mpc + 32'd4; end
      8'h02: begin mreg[d] = a + b;    mpc = mpc + 32'd4; end
      8'h03: begin mreg[d] = a - b;    mpc = mpc + 32'd4; end
      8'h04: begin mreg[d] = a & b;    mpc = mpc + 32'd4; end
      8'h05: begin mreg[d] = a | b;    mpc = mpc + 32'd4; end
      8'h06: mpc = br;
      8'h07: mpc = (a == b) ? br : mpc + 32'd4;
      8'hFF: mhalt = 1'b1;
      default: begin mill = 1'b1; mpc = mpc + 32'd4; end
    endcase
  endtask

  // Run one instruction starting at a FETCH-cycle negedge, with 'waits' ack-less cycles
  task automatic exec(input logic [31:0] ins, input int waits);
    logic [31:0] old_pc;
    old_pc = mpc;
    chk("fetch_req", 32'(INSTR_REQ), 32'd1);
    chk("fetch_pc", PC, mpc);
    chk("fetch_ret", 32'(RETIRED), 32'd0);
    chk("fetch_ill", 32'(ILLEGAL), 32'(mill));
    for (int w = 0; w < waits; w++) begin
      INSTR_VALID = 1'b0;
      INSTRUCTION = $urandom;
      @(negedge CLK);
      chk("wait_req", 32'(INSTR_REQ), 32'd1);
      chk("wait_pc", PC, old_pc);
      chk("wait_ret", 32'(RETIRED), 32'd0);
    end
    INSTR_VALID = 1'b1;
    INSTRUCTION = ins;
    @(negedge CLK);
    // DECODE: memory inputs are ignored, so drive noise
    INSTR_VALID = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    chk("dec_req", 32'(INSTR_REQ), 32'd0);
    chk("dec_ret", 32'(RETIRED), 32'd0);
    @(negedge CLK);
    // EXEC
    chk("exec_ret", 32'(RETIRED), 32'd0);
    chk("exec_halt", 32'(HALTED), 32'd0);
    chk("exec_ill", 32'(ILLEGAL), 32'(mill));
    model_apply(ins);
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    chk("post_pc", PC, old_pc);
    chk("post_ill", 32'(ILLEGAL), 32'(mill));
    if (mhalt) begin
      chk("halt_flag", 32'(HALTED), 32'd1);
      chk("halt_ret", 32'(RETIRED), 32'd0);
      chk("halt_req", 32'(INSTR_REQ), 32'd0);
    end else begin
      chk("wb_ret", 32'(RETIRED), 32'd1);
      chk("wb_halt", 32'(HALTED), 32'd0);
      @(negedge CLK);
    end
  endtask

  // Observe register r through beq against a freshly loaded value v
  task automatic check_reg(input int r, input logic [7:0] v);
    int tmp;
    tmp = (r + 1) % 8;
    exec(mk(8'h00, 8'(tmp), 8'h00, v), 0);
    exec(mk(8'h07, 8'h01, 8'(r), 8'(tmp)), 0);
  endtask

  // Jump to an absolute target near the current PC
  task automatic go_to(input logic [31:0] target);
    int off;
    off = (int'(target) - int'(mpc) - 4) / 4;
    exec(mk(8'h06, 8'(off), 8'h00, 8'h00), 0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [7:0]  op;
    int          sel;
    logic [31:0] hpc;

    RESET_N     = 1'b0;
    INSTR_VALID = 1'b0;
    INSTRUCTION = 32'd0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_pc", PC, 32'd0);
    chk("rst_req", 32'(INSTR_REQ), 32'd0);
    chk("rst_ret", 32'(RETIRED), 32'd0);
    chk("rst_halt", 32'(HALTED), 32'd0);
    chk("rst_ill", 32'(ILLEGAL), 32'd0);
    RESET_N = 1'b1;
    #1;
    chk("rel_req", 32'(INSTR_REQ), 32'd1);
    @(negedge CLK);

    // Test 1: loadi/loadi/add, 4-cycle zero-wait instructions
    exec(mk(8'h00, 8'h01, 8'h00, 8'h05), 0);
    exec(mk(8'h00, 8'h02, 8'h00, 8'h03), 0);
    exec(mk(8'h02, 8'h03, 8'h01, 8'h02), 0);
    chk("t1_pc", PC, 32'd12);
    check_reg(3, 8'h08);

    // Test 2: sub wraps, and/or
    exec(mk(8'h03, 8'h04, 8'h02, 8'h01), 0);
    check_reg(4, 8'hFE);
    exec(mk(8'h00, 8'h05, 8'h00, 8'hF0), 0);
    exec(mk(8'h00, 8'h06, 8'h00, 8'h3C), 0);
    exec(mk(8'h04, 8'h07, 8'h05, 8'h06), 0);
    check_reg(7, 8'h30);
    exec(mk(8'h05, 8'h07, 8'h05, 8'h06), 0);
    check_reg(7, 8'hFC);

    // Test 3: three wait cycles in FETCH
    exec(mk(8'h02, 8'h03, 8'h01, 8'h02), 3);
    check_reg(3, 8'h08);

    // Test 4: branches
    go_to(32'd8);
    exec(mk(8'h07, 8'hFE, 8'h01, 8'h01), 0);
    chk("beq_taken", PC, 32'd4);
    go_to(32'd8);
    exec(mk(8'h07, 8'hFE, 8'h01, 8'h02), 0);
    chk("beq_not_taken", PC, 32'd12);
    go_to(32'd0);
    exec(mk(8'h06, 8'h02, 8'h00, 8'h00), 0);
    chk("j_fwd", PC, 32'd12);
    go_to(32'd0);
    exec(mk(8'h06, 8'hFE, 8'h00, 8'h00), 0);
    chk("j_back_wrap", PC, 32'hFFFF_FFFC);
    exec(mk(8'h00, 8'h06, 8'h00, 8'h11), 0);
    chk("pc_wrap", PC, 32'd0);

    // Test 5: illegal opcode is sticky and writes nothing
    exec(mk(8'h3A, 8'h01, 8'h02, 8'h03), 0);
    chk("ill_set", 32'(ILLEGAL), 32'd1);
    chk("ill_pc", PC, 32'd4);
    check_reg(1, 8'h05);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 9) begin
        sel = $urandom_range(0, 7);
        check_reg(sel, mreg[sel]);
      end else begin
        if (sel == 8) op = 8'($urandom_range(8, 254));
        else          op = 8'(sel);
        ins = $urandom;
        ins[31:24] = op;
        exec(ins, $urandom_range(0, 2));
      end
    end
    chk("rand_ill", 32'(ILLEGAL), 32'(mill));

    // Test 6: reset mid-EXEC abandons the add
    exec(mk(8'h00, 8'h01, 8'h00, 8'h05), 0);
    exec(mk(8'h00, 8'h02, 8'h00, 8'h03), 0);
    INSTR_VALID = 1'b1;
    INSTRUCTION = mk(8'h02, 8'h03, 8'h01, 8'h02);
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_pc", PC, 32'd0);
    chk("mid_rst_req", 32'(INSTR_REQ), 32'd0);
    chk("mid_rst_ret", 32'(RETIRED), 32'd0);
    chk("mid_rst_halt", 32'(HALTED), 32'd0);
    chk("mid_rst_ill", 32'(ILLEGAL), 32'd0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_reg(3, 8'h00);
    check_reg(1, 8'h00);

    // Halt is absorbing; memory acks are ignored
    exec(mk(8'h00, 8'h02, 8'h00, 8'h7F), 0);
    hpc = mpc;
    exec(mk(8'hFF, 8'h00, 8'h00, 8'h00), 0);
    for (int k = 0; k < 6; k++) begin
      INSTR_VALID = 1'($urandom_range(0, 1));
      INSTRUCTION = mk(8'h00, 8'h01, 8'h00, 8'h01);
      @(negedge CLK);
      chk("halt_hold", 32'(HALTED), 32'd1);
      chk("halt_noreq", 32'(INSTR_REQ), 32'd0);
      chk("halt_noret", 32'(RETIRED), 32'd0);
      chk("halt_pc", PC, hpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
